inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Parametrised instruction fetcher with a direct-mapped icache of configurable depth and miss-driven refill.
//  Sits between memctrl and the dispatcher and issues at most one instruction per cycle, gated by global_full.
//  Flushes on a ROB-committed jump and drops any in-flight memctrl request.
//  Optionally predicts conditional branches with a 2-bit BHT.
// PARAMETERS
//  ADDR_W        32  pc / address width
//  INST_W        32  instruction width
//  ICACHE_LINES  64  icache entries, power of 2; index = pc[IDX_W+1:2], IDX_W = log2(ICACHE_LINES)
//  BHT_LINES     256 BHT entries, power of 2; index = pc[log2(BHT_LINES)+1:2]; used only with FETCH_BHT_EN
// PORTS
//  clk                   in   1       clock, rising edge
//  rst                   in   1       synchronous reset, active-high
//  rdy                   in   1       0 = freeze all state (outputs hold)
//  global_full           in   1       1 = downstream cannot accept an instruction
//  inst_to_dsp           out  INST_W  issued instruction
//  pc_to_dsp             out  ADDR_W  pc of issued instruction
//  pred_jump_to_dsp      out  1       1 = issued instruction was predicted taken
//  ok_flag_to_dsp        out  1       1-cycle pulse: inst/pc/pred valid
//  pc_to_mc              out  ADDR_W  refill address
//  ena_to_mc             out  1       1-cycle request pulse to memctrl
//  drop_flag_to_mc       out  1       1-cycle pulse: abort outstanding request
//  ok_flag_from_mc       in   1       refill data valid
//  inst_from_mc          in   INST_W  refill data
//  commit_jump_flag_from_rob  in  1       mispredict / jump redirect
//  target_pc_from_rob    in   ADDR_W  redirect target
//  commit_br_flag_from_rob    in  1       conditional branch committed (BHT update)
//  commit_br_pc_from_rob      in  ADDR_W  pc of committed branch
//  commit_br_taken_from_rob   in  1       actual outcome of committed branch
// BEHAVIOUR
//  Reset: pc=0, state=IDLE, all valid bits=0, BHT counters=2'b01 (weak not-taken); every output 0.
//  rdy=0: no state change, no output change. Reset has priority over rdy.
//  hit = valid[idx(pc)] && tag[idx(pc)]==pc (full-pc tag).
//  Issue: if hit && !global_full -> next cycle ok_flag_to_dsp=1, inst/pc set, pc <= next_pc; else ok_flag_to_dsp=0.
//   Hit-to-issue latency is 1 cycle; back-to-back hits issue every cycle.
//  next_pc = pc+4, or pc+imm_B when FETCH_BHT_EN is defined, the instruction is a B-type (opcode 7'b1100011)
//   and the BHT counter is >= 2'b10.
//  Refill FSM:
//   IDLE  -> on !hit: ena_to_mc=1 pulse, pc_to_mc=pc, req_pc<=pc; go to WAIT.
//   WAIT  -> on ok_flag_from_mc: write line idx(req_pc) (valid=1, tag=req_pc, data); go to IDLE.
//   The FSM fetches only the address that missed; no sequential prefetch. ena_to_mc is never asserted in WAIT.
//   Same-cycle refill write plus hit lookup: the lookup sees the old array contents; the hit occurs next cycle.
//  Redirect (commit_jump_flag_from_rob=1, highest priority after rst/rdy):
//   pc <= target_pc_from_rob; ok_flag_to_dsp=0; ena_to_mc=0; state <= IDLE.
//   drop_flag_to_mc=1 for one cycle only if state was WAIT.
//   An ok_flag_from_mc in the redirect cycle is discarded (no cache write). Icache contents are kept.
//  BHT update (commit_br_flag_from_rob): saturating +1 if taken, -1 if not, at idx(commit_br_pc).
//   The update is applied even in a redirect cycle.
//  Index and counter arithmetic wraps modulo width; pc+4 wraps at 2^ADDR_W.
// CONFIGURATION
//  FETCH_BHT_EN defined: BHT present; B-type target = pc + sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
//  FETCH_BHT_EN undefined: no BHT storage; next_pc is always pc+4; pred_jump_to_dsp is tied to 0;
//   commit_br_* inputs are ignored.
// TESTING
//  1. Reset, mem returns 0x00000013 for 0x0 after 3 cycles -> ena at 0x0, write line 0, issue pc=0 1 cycle after fill, then miss on 0x4.
//  2. Addresses 0x0..0x1C all cached, global_full=0 -> 8 consecutive ok pulses, pc_to_dsp 0x0,0x4,...,0x1C.
//  3. global_full=1 for 5 cycles on a hit -> no ok pulse, pc held; first issue 1 cycle after full drops.
//  4. Redirect to 0x100 while in WAIT, mc ok in the same cycle -> drop pulse, no cache write, next ena at pc_to_mc=0x100.
//  5. Alias: 0x0 cached, fetch 0x100 (same idx, 64 lines) -> miss, refill overwrites tag; a later fetch of 0x0 misses.
//  6. FETCH_BHT_EN: two taken commits at pc 0x8 (beq, imm=+16) -> next fetch of 0x8 issues with pred=1, then pc=0x18.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: dispatcher, memctrl and ROB-side signals.
// master = fetch unit, slave = the surrounding pipeline / bench.
interface inst_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
);
    logic              rdy;
    logic              global_full;

    logic [INST_W-1:0] inst_to_dsp;
    logic [ADDR_W-1:0] pc_to_dsp;
    logic              pred_jump_to_dsp;
    logic              ok_flag_to_dsp;

    logic [ADDR_W-1:0] pc_to_mc;
    logic              ena_to_mc;
    logic              drop_flag_to_mc;
    logic              ok_flag_from_mc;
    logic [INST_W-1:0] inst_from_mc;

    logic              commit_jump_flag_from_rob;
    logic [ADDR_W-1:0] target_pc_from_rob;
    logic              commit_br_flag_from_rob;
    logic [ADDR_W-1:0] commit_br_pc_from_rob;
    logic              commit_br_taken_from_rob;

    modport master (
        input  rdy, global_full,
        output inst_to_dsp, pc_to_dsp, pred_jump_to_dsp, ok_flag_to_dsp,
        output pc_to_mc, ena_to_mc, drop_flag_to_mc,
        input  ok_flag_from_mc, inst_from_mc,
        input  commit_jump_flag_from_rob, target_pc_from_rob,
        input  commit_br_flag_from_rob, commit_br_pc_from_rob, commit_br_taken_from_rob
    );

    modport slave (
        output rdy, global_full,
        input  inst_to_dsp, pc_to_dsp, pred_jump_to_dsp, ok_flag_to_dsp,
        input  pc_to_mc, ena_to_mc, drop_flag_to_mc,
        output ok_flag_from_mc, inst_from_mc,
        output commit_jump_flag_from_rob, target_pc_from_rob,
        output commit_br_flag_from_rob, commit_br_pc_from_rob, commit_br_taken_from_rob
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetcher: direct-mapped icache with full-pc tags, single
// outstanding miss refill from memctrl, one issue per cycle to the dispatcher.
// Optional 2-bit BHT branch prediction is built when FETCH_BHT_EN is defined.
module inst_fetch_unit #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned INST_W       = 32,
    parameter int unsigned ICACHE_LINES = 64,
    parameter int unsigned BHT_LINES    = 256
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_unit_if.master  bus
);
    localparam int unsigned IDX_W = $clog2(ICACHE_LINES);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       pc;
    logic [ADDR_W-1:0]       req_pc;
    logic [ICACHE_LINES-1:0] valid;
    logic [ADDR_W-1:0]       tag_mem  [ICACHE_LINES];
    logic [INST_W-1:0]       data_mem [ICACHE_LINES];

    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        fill_idx;
    logic [INST_W-1:0]       line_inst;
    logic                    hit;
    logic                    fill_we;
    logic [ADDR_W-1:0]       next_pc;
    logic                    pred_taken;

    assign idx       = pc[IDX_W+1:2];
    assign fill_idx  = req_pc[IDX_W+1:2];
    assign line_inst = data_mem[idx];
    assign hit       = valid[idx] && (tag_mem[idx] == pc);

    // A refill lands only when waiting and no redirect discards it.
    assign fill_we = !rst && bus.rdy && !bus.commit_jump_flag_from_rob
                     && (state == ST_WAIT) && bus.ok_flag_from_mc;

`ifdef FETCH_BHT_EN
    localparam int unsigned BHT_IDX_W = $clog2(BHT_LINES);

    logic [1:0]           bht [BHT_LINES];
    logic [BHT_IDX_W-1:0] bht_idx;
    logic [BHT_IDX_W-1:0] upd_idx;
    logic [ADDR_W-1:0]    imm_b;
    logic                 unused_br_pc;

    assign bht_idx = pc[BHT_IDX_W+1:2];
    assign upd_idx = bus.commit_br_pc_from_rob[BHT_IDX_W+1:2];
    assign imm_b   = {{(ADDR_W-13){line_inst[31]}}, line_inst[31], line_inst[7],
                      line_inst[30:25], line_inst[11:8], 1'b0};
    assign unused_br_pc = ^{bus.commit_br_pc_from_rob[ADDR_W-1:BHT_IDX_W+2],
                            bus.commit_br_pc_from_rob[1:0]};

    // Predict taken for B-type instructions whose counter is in a taken state.
    always_comb begin
        pred_taken = (line_inst[6:0] == 7'b1100011) && bht[bht_idx][1];
        next_pc    = pred_taken ? (pc + imm_b) : (pc + ADDR_W'(4));
    end

    // Saturating counter training from committed branches, redirect or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BHT_LINES); i++) begin
                bht[i] <= 2'b01;
            end
        end else if (bus.rdy && bus.commit_br_flag_from_rob) begin
            if (bus.commit_br_taken_from_rob) begin
                if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
            end else begin
                if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
        end
    end
`else
    localparam int unsigned UNUSED_BHT_LINES = BHT_LINES;

    logic unused_commit_br;

    assign pred_taken       = 1'b0;
    assign next_pc          = pc + ADDR_W'(4);
    assign unused_commit_br = ^{bus.commit_br_flag_from_rob, bus.commit_br_taken_from_rob,
                                bus.commit_br_pc_from_rob};
`endif

    // Tag/data arrays need no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[fill_idx]  <= req_pc;
            data_mem[fill_idx] <= bus.inst_from_mc;
        end
    end

    // Fetch pc, refill FSM, valid bits and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= ST_IDLE;
            pc                   <= '0;
            req_pc               <= '0;
            valid                <= '0;
            bus.inst_to_dsp      <= '0;
            bus.pc_to_dsp        <= '0;
            bus.pred_jump_to_dsp <= 1'b0;
            bus.ok_flag_to_dsp   <= 1'b0;
            bus.pc_to_mc         <= '0;
            bus.ena_to_mc        <= 1'b0;
            bus.drop_flag_to_mc  <= 1'b0;
        end else if (bus.rdy) begin
            bus.ok_flag_to_dsp  <= 1'b0;
            bus.ena_to_mc       <= 1'b0;
            bus.drop_flag_to_mc <= 1'b0;
            if (bus.commit_jump_flag_from_rob) begin
                pc                  <= bus.target_pc_from_rob;
                state               <= ST_IDLE;
                bus.drop_flag_to_mc <= (state == ST_WAIT);
            end else begin
                if (hit && !bus.global_full) begin
                    bus.ok_flag_to_dsp   <= 1'b1;
                    bus.inst_to_dsp      <= line_inst;
                    bus.pc_to_dsp        <= pc;
                    bus.pred_jump_to_dsp <= pred_taken;
                    pc                   <= next_pc;
                end
                if (state == ST_IDLE) begin
                    if (!hit) begin
                        bus.ena_to_mc <= 1'b1;
                        bus.pc_to_mc  <= pc;
                        req_pc        <= pc;
                        state         <= ST_WAIT;
                    end
                end else begin
                    if (bus.ok_flag_from_mc) begin
                        valid[fill_idx] <= 1'b1;
                        state           <= ST_IDLE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: refill, streaming, backpressure,
// redirect/drop, aliasing, BHT prediction (FETCH_BHT_EN) and rdy freeze.
module tb_inst_fetch_unit;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   ena_cnt   = 0;
    int   fill_cyc  = 0;
    int   c0        = 0;
    int   e0        = 0;
    logic consec;

    logic [31:0] iss_pc[$];
    logic [31:0] iss_inst[$];
    logic        iss_pred[$];
    int          iss_cyc[$];

    inst_fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    inst_fetch_unit #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .ICACHE_LINES(64), .BHT_LINES(256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every issue pulse and memctrl request.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ok_flag_to_dsp) begin
                iss_pc.push_back(bus.pc_to_dsp);
                iss_inst.push_back(bus.inst_to_dsp);
                iss_pred.push_back(bus.pred_jump_to_dsp);
                iss_cyc.push_back(cyc);
            end
            if (bus.ena_to_mc) ena_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8) return 32'h0000_0863;   // beq x0,x0,+16
        return {a[24:0], 7'h13};
    endfunction

    function automatic logic [31:0] q_pc(input int i);
        if (i < iss_pc.size()) return iss_pc[i];
        return 'x;
    endfunction

    function automatic logic [31:0] q_inst(input int i);
        if (i < iss_inst.size()) return iss_inst[i];
        return 'x;
    endfunction

    function automatic logic q_pred(input int i);
        if (i < iss_pred.size()) return iss_pred[i];
        return 1'bx;
    endfunction

    function automatic int q_cyc(input int i);
        if (i < iss_cyc.size()) return iss_cyc[i];
        return -1000;
    endfunction

    task automatic clear_q();
        iss_pc.delete();
        iss_inst.delete();
        iss_pred.delete();
        iss_cyc.delete();
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ena(input logic [31:0] addr, input string tag);
        int k = 0;
        do begin
            sample();
            k++;
        end while (!bus.ena_to_mc && k < 60);
        check({tag, "_ena"}, 32'(bus.ena_to_mc), 32'd1);
        check({tag, "_pc_to_mc"}, bus.pc_to_mc, addr);
    endtask

    task automatic mc_reply(input logic [31:0] data, input int lat);
        repeat (lat - 1) @(posedge clk);
        #1;
        bus.ok_flag_from_mc = 1'b1;
        bus.inst_from_mc    = data;
        @(posedge clk);
        #1;
        bus.ok_flag_from_mc = 1'b0;
        fill_cyc = cyc;
    endtask

    task automatic wait_issues(input int n, input string tag);
        int k = 0;
        while (iss_pc.size() < n && k < 60) begin
            sample();
            k++;
        end
        check(tag, 32'(iss_pc.size() >= n), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.commit_jump_flag_from_rob = 1'b1;
        bus.target_pc_from_rob        = target;
        @(posedge clk);
        #1;
        bus.commit_jump_flag_from_rob = 1'b0;
    endtask

    initial begin
        bus.rdy                       = 1'b0;
        bus.global_full               = 1'b0;
        bus.ok_flag_from_mc           = 1'b0;
        bus.inst_from_mc              = '0;
        bus.commit_jump_flag_from_rob = 1'b0;
        bus.target_pc_from_rob        = '0;
        bus.commit_br_flag_from_rob   = 1'b0;
        bus.commit_br_pc_from_rob     = '0;
        bus.commit_br_taken_from_rob  = 1'b0;

        // Reset wins over rdy=0: every output must come up zero.
        repeat (3) @(posedge clk);
        sample();
        check("rst_ok",   32'(bus.ok_flag_to_dsp), 32'd0);
        check("rst_ena",  32'(bus.ena_to_mc), 32'd0);
        check("rst_drop", 32'(bus.drop_flag_to_mc), 32'd0);
        check("rst_pred", 32'(bus.pred_jump_to_dsp), 32'd0);
        check("rst_inst", bus.inst_to_dsp, 32'd0);
        check("rst_pcd",  bus.pc_to_dsp, 32'd0);
        check("rst_pcmc", bus.pc_to_mc, 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        bus.rdy = 1'b1;

        // 1: cold miss at 0, 3-cycle refill, issue one cycle after the fill.
        wait_ena(32'h0, "t1_miss0");
        mc_reply(mem_word(32'h0), 3);
        wait_issues(1, "t1_issue");
        check("t1_pc",   q_pc(0), 32'h0);
        check("t1_inst", q_inst(0), 32'h0000_0013);
        check("t1_pred", 32'(q_pred(0)), 32'd0);
        check("t1_lat",  32'(q_cyc(0)), 32'(fill_cyc + 1));
        wait_ena(32'h4, "t1_miss4");

        // Fill 0x4..0x1C one miss at a time.
        for (int a = 4; a <= 'h1C; a += 4) begin
            if (a != 4) wait_ena(32'(a), "t2_fill");
            mc_reply(mem_word(32'(a)), 2);
        end
        wait_ena(32'h20, "t2_miss20");

        // 2: redirect to 0 from WAIT, then stream 8 hits back to back.
        clear_q();
        redirect(32'h0);
        sample();
        check("t2_drop", 32'(bus.drop_flag_to_mc), 32'd1);
        check("t2_okz",  32'(bus.ok_flag_to_dsp), 32'd0);
        check("t2_enaz", 32'(bus.ena_to_mc), 32'd0);
        wait_issues(8, "t2_count");
        consec = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t2_pc",   q_pc(i), 32'(i * 4));
            check("t2_inst", q_inst(i), mem_word(32'(i * 4)));
            if (q_cyc(i) != q_cyc(0) + i) consec = 1'b0;
        end
        check("t2_consec", 32'(consec), 32'd1);
        wait_ena(32'h20, "t2_miss20b");

        // 3: backpressure on a hit holds pc; issue follows one cycle after release.
        clear_q();
        e0 = ena_cnt;
        bus.global_full = 1'b1;
        redirect(32'h0);
        repeat (5) sample();
        check("t3_no_issue", 32'(iss_pc.size()), 32'd0);
        check("t3_no_ena",   32'(ena_cnt), 32'(e0));
        bus.global_full = 1'b0;
        c0 = cyc;
        wait_issues(1, "t3_issue");
        check("t3_pc",  q_pc(0), 32'h0);
        check("t3_lat", 32'(q_cyc(0)), 32'(c0 + 1));
        wait_issues(8, "t3_stream");
        wait_ena(32'h20, "t3_miss20");

        // 4: redirect to 0x100 with a same-cycle mc reply that must be dropped.
        bus.ok_flag_from_mc = 1'b1;
        bus.inst_from_mc    = mem_word(32'h20);
        redirect(32'h100);
        bus.ok_flag_from_mc = 1'b0;
        sample();
        check("t4_drop", 32'(bus.drop_flag_to_mc), 32'd1);
        wait_ena(32'h100, "t4_miss100");

        // 5: 0x100 aliases line 0; slow refill with no extra requests while waiting.
        clear_q();
        e0 = ena_cnt;
        mc_reply(mem_word(32'h100), 6);
        wait_issues(1, "t5_issue");
        check("t5_pc",     q_pc(0), 32'h100);
        check("t5_inst",   q_inst(0), mem_word(32'h100));
        check("t5_no_ena", 32'(ena_cnt), 32'(e0));
        wait_ena(32'h104, "t5_miss104");
        redirect(32'h0);
        sample();
        check("t5_drop", 32'(bus.drop_flag_to_mc), 32'd1);
        wait_ena(32'h0, "t5_alias_miss");
        check("t5_no_hit0", 32'(iss_pc.size()), 32'd1);

        // The dropped 0x20 reply must not have been written.
        redirect(32'h20);
        wait_ena(32'h20, "t4_nowrite");

        // 6: train BHT at 0x8 (NT x3 saturating, then T, T in the redirect cycle).
        clear_q();
        for (int i = 0; i < 4; i++) begin
            bus.commit_br_flag_from_rob  = 1'b1;
            bus.commit_br_pc_from_rob    = 32'h8;
            bus.commit_br_taken_from_rob = (i == 3);
            @(posedge clk);
            #1;
        end
        bus.commit_br_taken_from_rob = 1'b1;
        redirect(32'h8);
        bus.commit_br_flag_from_rob  = 1'b0;
        bus.commit_br_taken_from_rob = 1'b0;
        wait_issues(2, "t6_issue");
        check("t6_pc0",   q_pc(0), 32'h8);
        check("t6_inst0", q_inst(0), 32'h0000_0863);
`ifdef FETCH_BHT_EN
        check("t6_pred0", 32'(q_pred(0)), 32'd1);
        check("t6_pc1",   q_pc(1), 32'h18);
`else
        check("t6_pred0", 32'(q_pred(0)), 32'd0);
        check("t6_pc1",   q_pc(1), 32'hC);
`endif
        check("t6_pred1", 32'(q_pred(1)), 32'd0);
        wait_ena(32'h20, "t6_miss20");

        // 7: rdy=0 freezes state and outputs, including the drop pulse.
        clear_q();
        redirect(32'h4);
        bus.rdy = 1'b0;
        repeat (3) begin
            sample();
            check("t7_hold_drop", 32'(bus.drop_flag_to_mc), 32'd1);
            check("t7_hold_ok",   32'(bus.ok_flag_to_dsp), 32'd0);
        end
        bus.rdy = 1'b1;
        c0 = cyc;
        wait_issues(1, "t7_issue");
        check("t7_pc",     q_pc(0), 32'h4);
        check("t7_lat",    32'(q_cyc(0)), 32'(c0 + 1));
        check("t7_drop_0", 32'(bus.drop_flag_to_mc), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
